// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: MEM-stage request side, data_mem_ctrl command side,
// and buffer status. The slave modport is the store buffer; the master modport
// is the pipeline plus memory controller that surround it.
//
// Handshake semantics (both sides):
//   Request side: a load or store is presented by holding req_read/req_write
//   high. It is taken on the rising edge where req_stall is low. While
//   req_stall is high, every req_* input must stay stable.
//   Command side: an op is presented by holding ctrl_read/ctrl_write high. It
//   completes on the rising edge where ctrl_stall is low. Until then,
//   ctrl_address and ctrl_write_data stay stable.
interface store_buffer_if #(
  parameter int DEPTH = 4
);
  logic                     req_read;
  logic                     req_write;
  logic [31:0]              req_address;
  logic [31:0]              req_write_data;
  logic                     flush;
  logic [31:0]              req_read_data;
  logic                     req_stall;
  logic                     ctrl_read;
  logic                     ctrl_write;
  logic [31:0]              ctrl_address;
  logic [31:0]              ctrl_write_data;
  logic [31:0]              ctrl_read_data;
  logic                     ctrl_stall;
  logic [$clog2(DEPTH):0]   sb_count;
  logic                     sb_empty;

  modport slave (
    input  req_read, req_write, req_address, req_write_data, flush,
    input  ctrl_read_data, ctrl_stall,
    output req_read_data, req_stall,
    output ctrl_read, ctrl_write, ctrl_address, ctrl_write_data,
    output sb_count, sb_empty
  );

  modport master (
    output req_read, req_write, req_address, req_write_data, flush,
    output ctrl_read_data, ctrl_stall,
    input  req_read_data, req_stall,
    input  ctrl_read, ctrl_write, ctrl_address, ctrl_write_data,
    input  sb_count, sb_empty
  );
endinterface

// File: rtl/store_buffer.sv
// Word-granular store buffer. Stores are posted into a circular FIFO and drained
// to data_mem_ctrl in order. Loads are forwarded from the youngest matching
// entry, or else sent downstream as a read that shares the single port with
// drains. The FSM state is exported on dbg_state_o.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  store_buffer_if.slave   bus,
  output logic [1:0]      dbg_state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q;
  logic [29:0]     load_addr_q;

  logic [29:0]     addr_mem [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic            full, nonempty;
  logic            load_req, load_miss;
  logic            hit;
  logic [31:0]     hit_data;
  logic [AW-1:0]   idx;
  logic            op_read, op_write, op_done;
  logic [31:0]     op_addr, op_wdata;
  logic            stall, push, pop;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^bus.req_address[1:0];

  assign full      = (count_q == CW'(DEPTH));
  assign nonempty  = (count_q != '0);
  // A simultaneous read and write is treated as a store.
  assign load_req  = bus.req_read && !bus.req_write;
  assign load_miss = load_req && !hit;

  // Associative search oldest-to-youngest so the youngest match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if ((CW'(i) < count_q) && (addr_mem[idx] == bus.req_address[31:2])) begin
        hit      = 1'b1;
        hit_data = data_mem[idx];
      end
    end
  end

  // Downstream op selection; IDLE arbitrates and issues in the same cycle.
  always_comb begin
    op_read  = 1'b0;
    op_write = 1'b0;
    op_addr  = '0;
    op_wdata = '0;
    if (reset) begin
      case (state_q)
        ST_IDLE: begin
          if (nonempty && (full || bus.flush)) op_write = 1'b1;
          else if (load_miss)                   op_read  = 1'b1;
          else if (nonempty)                    op_write = 1'b1;
        end
        ST_LOAD:  op_read  = 1'b1;
        ST_DRAIN: op_write = 1'b1;
        default:  ;
      endcase
    end
    if (op_write) begin
      op_addr  = {addr_mem[head_q], 2'b00};
      op_wdata = data_mem[head_q];
    end else if (op_read) begin
      op_addr  = (state_q == ST_LOAD) ? {load_addr_q, 2'b00}
                                      : {bus.req_address[31:2], 2'b00};
    end
  end

  assign op_done = (op_read || op_write) && !bus.ctrl_stall;
  assign pop     = op_write && op_done;

  // Pipeline stall: flush drains first, stores wait for space, misses wait for the read.
  always_comb begin
    stall = 1'b0;
    if (reset) begin
      if (bus.flush && nonempty)  stall = 1'b1;
      else if (bus.req_write)     stall = full;
      else if (bus.req_read)      stall = hit ? 1'b0 : !(op_read && op_done);
    end
  end

  assign push = reset && bus.req_write && !stall;

  // FIFO pointer and occupancy next-state.
  always_comb begin
    head_d  = pop  ? head_q + AW'(1) : head_q;
    tail_d  = push ? tail_q + AW'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care until counted as occupied.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[tail_q] <= bus.req_address[31:2];
      data_mem[tail_q] <= bus.req_write_data;
    end
  end

  // Port FSM: leave IDLE only when the issued op did not complete at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      load_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_read && !op_done) begin
            state_q     <= ST_LOAD;
            load_addr_q <= bus.req_address[31:2];
          end else if (op_write && !op_done) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_LOAD, ST_DRAIN: begin
          if (op_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ctrl_read       = op_read;
  assign bus.ctrl_write      = op_write;
  assign bus.ctrl_address    = op_addr;
  assign bus.ctrl_write_data = op_wdata;
  assign bus.req_stall       = stall;
  assign bus.req_read_data   = (reset && load_req) ? (hit ? hit_data : bus.ctrl_read_data) : '0;
  assign bus.sb_count        = count_q;
  assign bus.sb_empty        = (count_q == '0);
  assign dbg_state_o         = state_q;
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: drives the MEM-stage side, models data_mem_ctrl as a
// memory with programmable stall, and checks loads and drains against an
// architectural model (last store per word, in program order).
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dbg_state;

  store_buffer_if #(.DEPTH(DEPTH)) bus ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock.
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stall_mode = 0;   // 0: never, 1: always, 2: random, 3: countdown
  int stall_left = 0;
  bit rd_seen = 1'b0;

  logic [63:0] exp_wr_q[$];   // {address, data} in expected drain order
  logic [31:0] exp_ld_q[$];   // expected load results in issue order
  int          wr_cyc_q[$];

  logic [31:0] mem  [logic [31:0]];  // downstream memory contents
  logic [31:0] arch [logic [31:0]];  // program-order view of memory

  always @(posedge clock) cyc++;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (arch.exists(a)) return arch[a];
    return init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // data_mem_ctrl model: stall pattern and read data settle after the driver.
  initial begin
    bus.ctrl_stall     = 1'b0;
    bus.ctrl_read_data = '0;
    forever begin
      @(posedge clock);
      #2;
      case (stall_mode)
        0: bus.ctrl_stall = 1'b0;
        1: bus.ctrl_stall = 1'b1;
        2: bus.ctrl_stall = ($urandom_range(0, 2) == 0);
        default: begin
          bus.ctrl_stall = (stall_left > 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      bus.ctrl_read_data = bus.ctrl_read ? mem_rd({bus.ctrl_address[31:2], 2'b00}) : $urandom;
    end
  end

  // Monitor / scoreboard: pops expectations whenever the DUT completes something.
  always @(negedge clock) begin
    logic [63:0] e;
    logic [31:0] l;
    if (reset) begin
      if (bus.ctrl_read) rd_seen = 1'b1;
      if (bus.ctrl_write && !bus.ctrl_stall) begin
        wr_cyc_q.push_back(cyc);
        mem[bus.ctrl_address] = bus.ctrl_write_data;
        if (exp_wr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=0x%08h required=none", bus.ctrl_address);
        end else begin
          e = exp_wr_q.pop_front();
          check("drain_addr", bus.ctrl_address, e[63:32]);
          check("drain_data", bus.ctrl_write_data, e[31:0]);
        end
      end
      if (bus.req_read && !bus.req_write && !bus.req_stall) begin
        if (exp_ld_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_load actual=0x%08h required=none", bus.req_read_data);
        end else begin
          l = exp_ld_q.pop_front();
          check("load_data", bus.req_read_data, l);
        end
      end
    end
  end

  // Protocol check on the request side.
  always @(negedge clock) begin
    if (reset) assert (!(bus.req_read && bus.req_write))
      else $error("req_read and req_write high together");
  end

  // Driver tasks: start and end at posedge+1.
  task automatic wait_accept(output int stalls);
    stalls = 0;
    forever begin
      @(negedge clock);
      if (!bus.req_stall) break;
      stalls++;
      if (stalls > 200) begin
        total++;
        bad++;
        $display("FAIL accept_timeout actual=stalled required=accepted");
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    bus.req_write      = 1'b1;
    bus.req_address    = a;
    bus.req_write_data = d;
    exp_wr_q.push_back({k, d});
    arch[k] = d;
    wait_accept(stalls);
    bus.req_write = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output int stalls);
    bus.req_read    = 1'b1;
    bus.req_address = a;
    exp_ld_q.push_back(model_rd({a[31:2], 2'b00}));
    wait_accept(stalls);
    bus.req_read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clock);
      if (bus.sb_empty) break;
      n++;
    end
    @(posedge clock);
    #1;
    check("empty_count", 32'(bus.sb_count), 0);
    check("all_drained", exp_wr_q.size(), 0);
  endtask

  // Watchdog.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Stimulus.
  initial begin
    int s;
    int n;
    logic [31:0] st_addr [3];
    logic [31:0] st_data [3];
    logic [31:0] a;
    int r;

    bus.req_read       = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_address    = '0;
    bus.req_write_data = '0;
    bus.flush          = 1'b0;

    // Reset state, with a pending load miss that must not leak out.
    repeat (2) @(posedge clock);
    #1;
    bus.req_read    = 1'b1;
    bus.req_address = 32'h0000_0F00;
    #1;
    check("rst_ctrl_read",  32'(bus.ctrl_read), 0);
    check("rst_ctrl_write", 32'(bus.ctrl_write), 0);
    check("rst_ctrl_addr",  bus.ctrl_address, 0);
    check("rst_req_stall",  32'(bus.req_stall), 0);
    check("rst_sb_empty",   32'(bus.sb_empty), 1);
    check("rst_sb_count",   32'(bus.sb_count), 0);
    bus.req_read = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Posted stores drained back-to-back.
    stall_mode = 0;
    st_addr = '{32'h100, 32'h104, 32'h108};
    st_data = '{32'hA, 32'hB, 32'hC};
    wr_cyc_q.delete();
    for (int i = 0; i < 3; i++) begin
      do_store(st_addr[i], st_data[i], s);
      check("post_store_stall", s, 0);
    end
    wait_empty();
    check("b2b_write_count", wr_cyc_q.size(), 3);
    if (wr_cyc_q.size() == 3) begin
      check("b2b_gap0", wr_cyc_q[1] - wr_cyc_q[0], 1);
      check("b2b_gap1", wr_cyc_q[2] - wr_cyc_q[1], 1);
    end

    // Forwarding from the youngest of two matching stores.
    stall_mode = 1;
    rd_seen = 1'b0;
    do_store(32'h200, 32'h11, s);
    do_store(32'h200, 32'h22, s);
    do_load(32'h203, s);
    check("fwd_stall", s, 0);
    check("fwd_no_ctrl_read", 32'(rd_seen), 0);

    // Fill to DEPTH, then the fifth store waits for a pop.
    do_store(32'h204, 32'h1, s);
    check("fill_stall3", s, 0);
    do_store(32'h208, 32'h2, s);
    check("fill_stall4", s, 0);
    bus.req_write      = 1'b1;
    bus.req_address    = 32'h20C;
    bus.req_write_data = 32'h3;
    exp_wr_q.push_back({32'h20C, 32'h3});
    arch[32'h20C] = 32'h3;
    @(negedge clock);
    check("full_stall", 32'(bus.req_stall), 1);
    check("full_count", 32'(bus.sb_count), DEPTH);
    @(posedge clock);
    #1;
    stall_mode = 0;
    @(negedge clock);
    check("full_stall_pop_cycle", 32'(bus.req_stall), 1);
    @(negedge clock);
    check("full_accept", 32'(bus.req_stall), 0);
    @(posedge clock);
    #1;
    bus.req_write = 1'b0;
    wait_empty();

    // Load miss beats the next drain once the outstanding drain completes.
    stall_mode = 1;
    do_store(32'h220, 32'h5, s);
    do_store(32'h224, 32'h6, s);
    stall_mode      = 0;
    bus.req_read    = 1'b1;
    bus.req_address = 32'h300;
    exp_ld_q.push_back(model_rd(32'h300));
    @(negedge clock);
    check("prio_drain_first", 32'(bus.ctrl_write), 1);
    check("prio_load_waits", 32'(bus.req_stall), 1);
    @(negedge clock);
    check("prio_read_issued", 32'(bus.ctrl_read), 1);
    check("prio_no_write", 32'(bus.ctrl_write), 0);
    check("prio_read_addr", bus.ctrl_address, 32'h300);
    check("prio_read_done", 32'(bus.req_stall), 0);
    @(posedge clock);
    #1;
    bus.req_read = 1'b0;
    wait_empty();

    // Load miss behind a drain stalled for three cycles.
    do_store(32'h500, 32'h55, s);
    stall_left = 3;
    stall_mode = 3;
    idle(1);
    do_load(32'h400, s);
    check("miss_behind_drain_stall", s, 3);
    stall_mode = 0;
    wait_empty();

    // Flush with three entries buffered.
    stall_mode = 1;
    do_store(32'h600, 32'h61, s);
    do_store(32'h604, 32'h62, s);
    do_store(32'h608, 32'h63, s);
    bus.flush  = 1'b1;
    stall_mode = 0;
    n = 0;
    while (n < 100) begin
      @(negedge clock);
      if (!bus.req_stall) break;
      n++;
    end
    check("flush_stall_cycles", n, 3);
    check("flush_empty", 32'(bus.sb_empty), 1);
    @(posedge clock);
    #1;
    bus.flush = 1'b0;
    wait_empty();

    // Randomized mix against the architectural model.
    stall_mode = 2;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      if (r < 5) begin
        do_store(a, $urandom, s);
      end else if (r < 9) begin
        do_load(a + 32'($urandom_range(0, 3)), s);
      end else begin
        idle(1);
      end
    end
    stall_mode = 0;
    wait_empty();
    check("loads_all_seen", exp_ld_q.size(), 0);

    // Reset in the middle of an outstanding drain.
    stall_mode = 1;
    do_store(32'h700, 32'h71, s);
    do_store(32'h704, 32'h72, s);
    @(negedge clock);
    check("pre_reset_write", 32'(bus.ctrl_write), 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_reset_write", 32'(bus.ctrl_write), 0);
    check("mid_reset_count", 32'(bus.sb_count), 0);
    check("mid_reset_empty", 32'(bus.sb_empty), 1);
    exp_wr_q.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    stall_mode = 0;
    wr_cyc_q.delete();
    idle(6);
    check("post_reset_writes", wr_cyc_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Word-granular store buffer between the pipeline MEM stage and `data_mem_ctrl`. Stores are posted into a FIFO and retire without stalling the pipeline. Loads are forwarded from the youngest matching buffered store. Non-matching loads, and drained stores, share the single downstream port of `data_mem_ctrl`, whose `stall` output provides the downstream back-pressure.

## Interface
- `DEPTH`, 4, number of entries; power of two, minimum 2
- `clock`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low
- `req_read`  in  1  load request from MEM stage
- `req_write`  in  1  store request from MEM stage
- `req_address`  in  32  byte address; bits [1:0] ignored (word access only)
- `req_write_data`  in  32  store data
- `flush`  in  1  stall the pipeline until the buffer is empty
- `req_read_data`  out  32  load result, valid when `req_read` is high and `req_stall` is low
- `req_stall`  out  1  pipeline must hold all `req_*` inputs stable
- `ctrl_read`  out  1  read command to `data_mem_ctrl`
- `ctrl_write`  out  1  write command to `data_mem_ctrl`
- `ctrl_address`  out  32  address to `data_mem_ctrl`
- `ctrl_write_data`  out  32  write data to `data_mem_ctrl`
- `ctrl_read_data`  in  32  read data from `data_mem_ctrl`
- `ctrl_stall`  in  1  `data_mem_ctrl` stall output
- `sb_count`  out  log2(DEPTH)+1  occupied entries
- `sb_empty`  out  1  `sb_count == 0`

## Operation
- Circular FIFO of {address[31:2], data}, with head/tail pointers of log2(DEPTH) bits plus a count. Pointers wrap modulo DEPTH.
- Downstream completion:
  - A downstream op completes on a rising edge where (`ctrl_read` or `ctrl_write`) is high and `ctrl_stall` is low.
  - While an op is outstanding, `ctrl_address` and `ctrl_write_data` are held stable.
- FSM states:
  - **IDLE**, arbitration cycle. Priority order: 1) drain if the buffer is full or `flush` is high; 2) load miss; 3) drain if the buffer is non-empty; 4) nothing.
  - **LOAD**, a load miss is outstanding.
  - **DRAIN**, the head entry is outstanding.
- IDLE drives the chosen op combinationally in the same cycle:
  - If the op completes that cycle, the FSM stays in IDLE.
  - Otherwise it goes to LOAD or DRAIN.
- LOAD and DRAIN:
  - Keep driving the op until completion, then return to IDLE.
  - A drain completion pops the head.
- Store accepted (`req_write` high, `req_stall` low):
  - Enqueued at the tail on the clock edge.
  - Accepted only when count < DEPTH; when full, `req_stall` stays high until count < DEPTH at the start of a cycle.
  - A store and a pop in the same cycle leave count unchanged.
- No coalescing: a store to an address already buffered appends a new entry.
- Load:
  - Compare address[31:2] against all valid entries; the youngest match wins.
  - On a hit: `req_read_data` = entry data, `req_stall` = 0, no downstream read.
  - On a miss: `req_read_data` = `ctrl_read_data`; `req_stall` stays high until the LOAD op completes.
  - A load miss waits while a DRAIN is outstanding.
- `req_read` and `req_write` both high: treated as a store only (protocol violation; a bench assertion flags it).
- `flush` high: `req_stall` = 1 until `sb_empty`. Loads and stores are not accepted meanwhile.
- Outputs with no activity: `ctrl_read`, `ctrl_write` = 0; `ctrl_address`, `ctrl_write_data`, `req_read_data` = 0.

## Timing
- While `reset` is low, all of the following hold immediately, with no clock edge needed:
  - count = 0, pointers = 0, state = IDLE, `sb_empty` = 1;
  - all `ctrl_*` outputs = 0, `req_stall` = 0.
- Reset mid-drain: buffered stores are discarded and `ctrl_write` drops asynchronously.
- Latencies:
  - Store accept: 0 stall cycles when not full.
  - Forwarded load: 0 stall cycles.
  - Load miss: equals the number of cycles `ctrl_stall` stays high.
- Drain throughput: at most one entry per cycle; back-to-back drains complete in consecutive cycles when `ctrl_stall` is low.
- `sb_count` and `sb_empty` are registered and update on the edge after the push or pop.

## Test plan
- **Posted stores, back-to-back drain:** reset, then stores to 0x100=0xA, 0x104=0xB, 0x108=0xC with `ctrl_stall` tied 0 → no `req_stall`; `ctrl_write` for 0x100, 0x104, 0x108 in order, one per cycle; `sb_count` returns to 0.
- **Forwarding:** hold `ctrl_stall`=1; stores 0x200=0x11 then 0x200=0x22; load 0x203 → `req_read_data`=0x22, `req_stall`=0, `ctrl_read` never asserted.
- **Full buffer and load priority:**
  - DEPTH=4, `ctrl_stall`=1: the 5th store sees `req_stall`=1; releasing `ctrl_stall` pops one entry and accepts the 5th store on the next cycle.
  - With 2 entries buffered, `ctrl_stall`=0, load 0x300 (miss) → `ctrl_read` is issued before the next drain.
- **Load miss during outstanding drain:** `ctrl_stall` high for 3 cycles during a drain; load 0x400 arrives → stays stalled until the drain completes, then `ctrl_read` 0x400 is issued and returns `ctrl_read_data`.
- **Flush and reset:**
  - `flush` high with 3 entries → `req_stall`=1 until `sb_empty`=1, then low.
  - Assert `reset` low mid-DRAIN → `ctrl_write`=0 and `sb_count`=0 immediately, with no further writes after release.
